// File: rtl/d_latch.sv
// FPGA-safe D latch: a clocked hold register per bit plus a combinational
// transparent path. Q follows D while En is high and holds the value sampled
// at the last rising clk edge where En was high. No real latch is inferred.

// Per-bit storage slice: hold flop, transparent mux and a change indication.
module d_latch_lane #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    input  logic en,
    output logic q,
    output logic upd
);

    logic hold;

    // Capture d on every enabled edge; reset loads this bit of RESET_VAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold <= RST_BIT;
        else if (en)
            hold <= d;
    end

    // Zero-latency bypass while transparent, stored value while opaque.
    assign q   = en ? d : hold;

    // High when the coming edge will load a different value into this bit.
    assign upd = en & (d ^ hold);

endmodule

module d_latch #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    input  logic             En,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             held,
    output logic             captured,
    output logic             changed
);

    logic [WIDTH-1:0] upd;

    // Bits are fully independent, so each one gets its own slice.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        d_latch_lane #(
            .RST_BIT (RESET_VAL[i])
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (D[i]),
            .en    (En),
            .q     (Q[i]),
            .upd   (upd[i])
        );
    end

    assign Qn   = ~Q;
    assign held = ~En;

    // Sticky capture flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            captured <= 1'b0;
        else if (En)
            captured <= 1'b1;
    end

    // One-cycle pulse after an edge that altered the hold register; upd is
    // already gated by En, so opaque edges clear the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            changed <= 1'b0;
        else
            changed <= |upd;
    end

endmodule

// File: tb/tb_d_latch.sv
// Directed bench for d_latch: a vector table on a 1-bit instance plus a
// hand-written async-reset sequence on an 8-bit instance (RESET_VAL=8'hA5).
module tb_d_latch;

    logic       clk;
    int         checks;
    int         errors;

    // 1-bit instance
    logic       rst_a_n, en_a;
    logic [0:0] d_a, q_a, qn_a;
    logic       held_a, cap_a, chg_a;

    // 8-bit instance
    logic       rst_b_n, en_b;
    logic [7:0] d_b, q_b, qn_b;
    logic       held_b, cap_b, chg_b;

    d_latch #(.WIDTH(1), .RESET_VAL(1'b0)) u_a (
        .clk      (clk),
        .rst_n    (rst_a_n),
        .D        (d_a),
        .En       (en_a),
        .Q        (q_a),
        .Qn       (qn_a),
        .held     (held_a),
        .captured (cap_a),
        .changed  (chg_a)
    );

    d_latch #(.WIDTH(8), .RESET_VAL(8'hA5)) u_b (
        .clk      (clk),
        .rst_n    (rst_b_n),
        .D        (d_b),
        .En       (en_b),
        .Q        (q_b),
        .Qn       (qn_b),
        .held     (held_b),
        .captured (cap_b),
        .changed  (chg_b)
    );

    typedef struct {
        logic rst_n;
        logic en;
        logic d;
        int   nclk;
        logic q;
        logic cap;
        logic chg;
    } vec_t;

    vec_t vecs[19];

    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        clk     = 1'b0;
        checks  = 0;
        errors  = 0;
        rst_a_n = 1'b0; en_a = 1'b0; d_a = 1'b0;
        rst_b_n = 1'b0; en_b = 1'b0; d_b = 8'h00;

        //            rst  en   d   clk  q    cap  chg
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0}; // reset, opaque
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0}; // reset held over edge
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0}; // D=1 ignored while opaque
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0}; // transparent D=0
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0}; // Q follows D before edge
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1}; // capture 0->1, pulse
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0}; // pulse lasts one cycle
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0}; // hold 1
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0}; // toggle D while held
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1}; // capture 0
        vecs[12] = '{1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b1}; // late D change, no edge
        vecs[13] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1}; // En falls: back to 0
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b1, 1'b0}; // capture same value
        vecs[16] = '{1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0}; // reset, transparent
        vecs[17] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0}; // reset, opaque
        vecs[18] = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1}; // first capture after release

        foreach (vecs[i]) begin
            rst_a_n = vecs[i].rst_n;
            en_a    = vecs[i].en;
            d_a     = vecs[i].d;
            #1;
            for (int k = 0; k < vecs[i].nclk; k++) tick();
            #1;
            chk($sformatf("v%0d.q", i),        {7'b0, q_a},    {7'b0, vecs[i].q});
            chk($sformatf("v%0d.qn", i),       {7'b0, qn_a},   {7'b0, ~vecs[i].q});
            chk($sformatf("v%0d.held", i),     {7'b0, held_a}, {7'b0, ~vecs[i].en});
            chk($sformatf("v%0d.captured", i), {7'b0, cap_a},  {7'b0, vecs[i].cap});
            chk($sformatf("v%0d.changed", i),  {7'b0, chg_a},  {7'b0, vecs[i].chg});
        end

        // 8-bit: reset value visible while opaque
        #1;
        chk("b.reset_q", q_b, 8'hA5);
        chk("b.reset_qn", qn_b, 8'h5A);
        chk("b.reset_cap", {7'b0, cap_b}, 8'h00);

        // capture 3C then hold it
        rst_b_n = 1'b1; en_b = 1'b1; d_b = 8'h3C;
        #1; tick();
        en_b = 1'b0; d_b = 8'hFF;
        #1;
        chk("b.hold_q", q_b, 8'h3C);
        chk("b.hold_held", {7'b0, held_b}, 8'h01);
        chk("b.hold_cap", {7'b0, cap_b}, 8'h01);
        chk("b.hold_chg", {7'b0, chg_b}, 8'h01);
        tick(); #1;
        chk("b.hold_q2", q_b, 8'h3C);
        chk("b.hold_chg2", {7'b0, chg_b}, 8'h00);

        // async reset pulse between edges
        #2 rst_b_n = 1'b0;
        #1;
        chk("b.async_q", q_b, 8'hA5);
        chk("b.async_cap", {7'b0, cap_b}, 8'h00);
        chk("b.async_chg", {7'b0, chg_b}, 8'h00);
        rst_b_n = 1'b1;
        #1;
        chk("b.release_q", q_b, 8'hA5);

        // re-capture 5A on the next edge
        en_b = 1'b1; d_b = 8'h5A;
        #1;
        chk("b.transp_q", q_b, 8'h5A);
        tick();
        en_b = 1'b0; d_b = 8'h00;
        #1;
        chk("b.recap_q", q_b, 8'h5A);
        chk("b.recap_cap", {7'b0, cap_b}, 8'h01);
        chk("b.recap_chg", {7'b0, chg_b}, 8'h01);
        tick(); #1;
        chk("b.recap_q2", q_b, 8'h5A);
        chk("b.recap_chg2", {7'b0, chg_b}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
